// File: rtl/br_delay_pkg.sv
// Shared helpers for the br_delay valid-next family: lane popcount and occupancy count width.
package br_delay_pkg;

   // Widest lane vector the popcount helper accepts; callers zero-extend into it.
   localparam int unsigned MaxLanes = 256;

   function automatic int unsigned popcount(input logic [MaxLanes-1:0] vec);
      int unsigned n = 0;
      for (int i = 0; i < MaxLanes; i++) begin
         n += 32'(vec[i]);
      end
      return n;
   endfunction

   function automatic int unsigned count_width(input int unsigned num_stages,
                                                input int unsigned num_lanes);
      int unsigned w = $clog2(num_stages * num_lanes + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/br_delay_valid_next_lane.sv
// One lane of the valid-next delay line: flushable vn chain plus a data chain gated by vn.
// Define BR_DELAY_VALID_NEXT_DATA_RESET_EN to give the data registers an async reset.
module br_delay_valid_next_lane #(
   parameter int unsigned  BitWidth  = 1,
   parameter int unsigned  NumStages = 0,
   localparam int unsigned VnWidth   = (NumStages > 0) ? NumStages : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush_i,
   input  logic                valid_next_i,
   input  logic [BitWidth-1:0] data_i,
   output logic                valid_next_o,
   output logic [BitWidth-1:0] data_o,
   output logic [VnWidth-1:0]  vn_o
);

   if (NumStages == 0) begin : g_passthru
      logic unused_ctrl;
      assign unused_ctrl  = clk ^ rst_n ^ flush_i;
      assign valid_next_o = valid_next_i;
      assign data_o       = data_i;
      assign vn_o         = '0;
   end else begin : g_pipe
      logic [NumStages:1]                vn_q, vn_d;
      logic [NumStages:0]                vn_all;
      logic [NumStages:1][BitWidth-1:0]  data_q;
      logic [NumStages:0][BitWidth-1:0]  data_all;

      assign vn_all   = {vn_q, valid_next_i};
      assign data_all = {data_q, data_i};

      always_comb begin
         vn_d = '0;
         for (int i = 1; i <= NumStages; i++) begin
            vn_d[i] = vn_all[i-1] & ~flush_i;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vn_q <= '0;
         end else begin
            vn_q <= vn_d;
         end
      end

      // vn[i] qualifies data[i-1], so stage i loads only while its own vn is set.
`ifdef BR_DELAY_VALID_NEXT_DATA_RESET_EN
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q <= '0;
         end else begin
            for (int i = 1; i <= NumStages; i++) begin
               if (vn_q[i]) data_q[i] <= data_all[i-1];
            end
         end
      end
`else
      always_ff @(posedge clk) begin
         for (int i = 1; i <= NumStages; i++) begin
            if (vn_q[i]) data_q[i] <= data_all[i-1];
         end
      end
`endif

      assign valid_next_o = vn_q[NumStages];
      assign data_o       = data_q[NumStages];
      assign vn_o         = vn_q;
   end

endmodule

// File: rtl/br_delay_valid_next_lanes.sv
// Multi-lane flushable valid-next delay line with a registered in-flight occupancy count.
// Define BR_DELAY_VALID_NEXT_DATA_RESET_EN to reset the data registers as well.
module br_delay_valid_next_lanes
   import br_delay_pkg::*;
#(
   parameter int unsigned  BitWidth   = 1,
   parameter int unsigned  NumLanes   = 1,
   parameter int unsigned  NumStages  = 0,
   localparam int unsigned CountWidth = count_width(NumStages, NumLanes)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [NumLanes-1:0]          in_valid_next,
   input  logic [NumLanes*BitWidth-1:0] in,
   output logic [NumLanes-1:0]          out_valid_next,
   output logic [NumLanes*BitWidth-1:0] out,
   output logic [CountWidth-1:0]        in_flight
);

   localparam int unsigned VnWidth = (NumStages > 0) ? NumStages : 1;

   logic [NumLanes-1:0][VnWidth-1:0] lane_vn;

   for (genvar k = 0; k < NumLanes; k++) begin : g_lane
      br_delay_valid_next_lane #(
         .BitWidth  (BitWidth),
         .NumStages (NumStages)
      ) u_lane (
         .clk          (clk),
         .rst_n        (rst_n),
         .flush_i      (flush),
         .valid_next_i (in_valid_next[k]),
         .data_i       (in[k*BitWidth +: BitWidth]),
         .valid_next_o (out_valid_next[k]),
         .data_o       (out[k*BitWidth +: BitWidth]),
         .vn_o         (lane_vn[k])
      );
   end

`ifndef SYNTHESIS
   a_params: assert property (@(posedge clk)
      BitWidth >= 1 && NumLanes >= 1 && NumLanes <= MaxLanes);
`endif

   if (NumStages == 0) begin : g_no_count
      logic unused_vn;
      assign unused_vn = ^lane_vn;
      assign in_flight = '0;
   end else begin : g_count
      logic [MaxLanes-1:0]   in_vn_ext, out_vn_ext;
      logic [CountWidth-1:0] in_flight_q, in_flight_d;

      assign in_vn_ext  = MaxLanes'(in_valid_next);
      assign out_vn_ext = MaxLanes'(out_valid_next);

      // Items leaving stage NumStages are always counted, so the subtraction cannot underflow.
      always_comb begin
         in_flight_d = '0;
         if (!flush) begin
            in_flight_d = CountWidth'(32'(in_flight_q) + popcount(in_vn_ext)
                                      - popcount(out_vn_ext));
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            in_flight_q <= '0;
         end else begin
            in_flight_q <= in_flight_d;
         end
      end

      assign in_flight = in_flight_q;

`ifndef SYNTHESIS
      int unsigned        vn_count;
      logic [NumStages:0] hist_all;
      // A set bit means the pipeline was emptied (reset or flush) within the last NumStages edges.
      logic [NumStages-1:0] kill_hist_q;

      always_comb begin
         vn_count = 0;
         for (int k = 0; k < NumLanes; k++) begin
            for (int i = 0; i < NumStages; i++) begin
               vn_count += 32'(lane_vn[k][i]);
            end
         end
      end

      assign hist_all = {kill_hist_q, flush};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            kill_hist_q <= '1;
         end else begin
            kill_hist_q <= hist_all[NumStages-1:0];
         end
      end

      a_count: assert property (@(posedge clk) disable iff (!rst_n)
         32'(in_flight_q) == vn_count);
      a_flush_quiet: assert property (@(posedge clk) disable iff (!rst_n)
         (|kill_hist_q) |-> (out_valid_next == '0));
      a_valid_delay: assert property (@(posedge clk) disable iff (!rst_n)
         (kill_hist_q == '0) |-> (out_valid_next == $past(in_valid_next, NumStages)));
      c_flush_busy: cover property (@(posedge clk) disable iff (!rst_n)
         flush && (in_flight_q != '0));

      for (genvar k = 0; k < NumLanes; k++) begin : g_data_chk
         a_data_delay: assert property (@(posedge clk) disable iff (!rst_n)
            $past(out_valid_next[k] && (kill_hist_q == '0)) |->
            (out[k*BitWidth +: BitWidth] == $past(in[k*BitWidth +: BitWidth], NumStages)));
      end
`endif
   end

endmodule

// File: tb/tb_br_delay_valid_next_lanes.sv
// Bench for br_delay_valid_next_lanes: several configurations against a cycle-history model.
// Optional BR_DELAY_VALID_NEXT_DATA_RESET_EN also checks data reset values.
module tb_br_delay_valid_next_lanes;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   // A: 3 stages, 1 lane
   logic       a_flush = 1'b0, a_vn = 1'b0, a_ovn;
   logic [7:0] a_in = '0, a_out;
   logic [1:0] a_if;
   // B: 4 stages, 2 lanes
   localparam int NB = 4;
   logic        b_flush = 1'b0;
   logic [1:0]  b_vn = '0, b_ovn;
   logic [15:0] b_in = '0, b_out;
   logic [3:0]  b_if;
   // C: passthrough, 2 lanes
   logic        c_flush = 1'b0;
   logic [1:0]  c_vn = '0, c_ovn;
   logic [15:0] c_in = '0, c_out;
   logic [0:0]  c_if;
   // D: 1 stage, 3 lanes
   logic        d_flush = 1'b0;
   logic [2:0]  d_vn = '0, d_ovn;
   logic [23:0] d_in = '0, d_out;
   logic [1:0]  d_if;
   // E: 2 stages, 4 lanes
   logic        e_flush = 1'b0;
   logic [3:0]  e_vn = '0, e_ovn;
   logic [31:0] e_in = '0, e_out;
   logic [3:0]  e_if;

   br_delay_valid_next_lanes #(.BitWidth(8), .NumLanes(1), .NumStages(3)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid_next(a_vn), .in(a_in),
      .out_valid_next(a_ovn), .out(a_out), .in_flight(a_if));
   br_delay_valid_next_lanes #(.BitWidth(8), .NumLanes(2), .NumStages(NB)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid_next(b_vn), .in(b_in),
      .out_valid_next(b_ovn), .out(b_out), .in_flight(b_if));
   br_delay_valid_next_lanes #(.BitWidth(8), .NumLanes(2), .NumStages(0)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid_next(c_vn), .in(c_in),
      .out_valid_next(c_ovn), .out(c_out), .in_flight(c_if));
   br_delay_valid_next_lanes #(.BitWidth(8), .NumLanes(3), .NumStages(1)) u_d (
      .clk(clk), .rst_n(rst_n), .flush(d_flush), .in_valid_next(d_vn), .in(d_in),
      .out_valid_next(d_ovn), .out(d_out), .in_flight(d_if));
   br_delay_valid_next_lanes #(.BitWidth(8), .NumLanes(4), .NumStages(2)) u_e (
      .clk(clk), .rst_n(rst_n), .flush(e_flush), .in_valid_next(e_vn), .in(e_in),
      .out_valid_next(e_ovn), .out(e_out), .in_flight(e_if));

   task automatic test_reset();
      #2;
      tests++;
      if (a_ovn !== 1'b0 || a_if !== 2'd0) begin
         fails++; $display("FAIL reset_a: ovn=%b if=%0d, want 0/0", a_ovn, a_if);
      end
      tests++;
      if (b_ovn !== 2'b00 || b_if !== 4'd0) begin
         fails++; $display("FAIL reset_b: ovn=%b if=%0d, want 00/0", b_ovn, b_if);
      end
      tests++;
      if (e_ovn !== 4'b0000 || e_if !== 4'd0) begin
         fails++; $display("FAIL reset_e: ovn=%b if=%0d, want 0000/0", e_ovn, e_if);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         a_vn = (c == 0);
         a_in = (c == 1) ? 8'hA5 : 8'h00;
         @(negedge clk);
         tests++;
         if (a_ovn !== (c == 3)) begin
            fails++; $display("FAIL single_ovn c=%0d: got %b want %b", c, a_ovn, (c == 3));
         end
         tests++;
         if (a_if !== ((c >= 1 && c <= 3) ? 2'd1 : 2'd0)) begin
            fails++; $display("FAIL single_inflight c=%0d: got %0d", c, a_if);
         end
         if (c == 4) begin
            tests++;
            if (a_out !== 8'hA5) begin
               fails++; $display("FAIL single_out: got %h want a5", a_out);
            end
         end
      end
   endtask

   task automatic test_idle_lanes();
      logic [7:0] l1, l3;
      l1 = e_out[15:8];
      l3 = e_out[31:24];
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         e_vn = 4'b0101;
         e_in = $urandom;
         @(negedge clk);
         if (c >= 2) begin
            tests++;
            if (e_if !== 4'd4) begin
               fails++; $display("FAIL idle_inflight c=%0d: got %0d want 4", c, e_if);
            end
            tests++;
            if (e_ovn !== 4'b0101) begin
               fails++; $display("FAIL idle_ovn c=%0d: got %b want 0101", c, e_ovn);
            end
         end
      end
      tests++;
      if (e_out[15:8] !== l1 || e_out[31:24] !== l3) begin
         fails++; $display("FAIL idle_data: lanes1/3 %h/%h were %h/%h", e_out[15:8],
                           e_out[31:24], l1, l3);
      end
      @(posedge clk); #1;
      e_vn = '0;
   endtask

   task automatic test_passthrough();
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         c_vn = 2'($urandom);
         c_in = 16'($urandom);
         c_flush = 1'($urandom);
         #1;
         tests++;
         if (c_ovn !== c_vn || c_out !== c_in || c_if !== 1'b0) begin
            fails++; $display("FAIL passthru c=%0d: ovn=%b out=%h if=%0d want %b %h 0", c,
                              c_ovn, c_out, c_if, c_vn, c_in);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] prev_in;
      prev_in = '0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         d_vn = 3'b111;
         d_in = 24'($urandom);
         @(negedge clk);
         if (c >= 1) begin
            tests++;
            if (d_if !== 2'd3 || d_ovn !== 3'b111) begin
               fails++; $display("FAIL b2b_valid c=%0d: if=%0d ovn=%b want 3/111", c, d_if,
                                 d_ovn);
            end
         end
         if (c >= 2) begin
            tests++;
            if (d_out !== prev_in) begin
               fails++; $display("FAIL b2b_data c=%0d: got %h want %h", c, d_out, prev_in);
            end
         end
         prev_in = d_in;
      end
      @(posedge clk); #1;
      d_vn = '0;
   endtask

   // Model: an item entered at cycle u is still live at cycle n if no flush occurred in [u, n-1].
   task automatic test_random();
      logic [1:0]  hv [160];
      logic [15:0] hd [160];
      bit          hf [160];
      logic [1:0]  exp_v, prev_exp_v;
      int          exp_cnt;
      bit          alive;
      prev_exp_v = '0;
      for (int n = 0; n < 160; n++) begin
         @(posedge clk); #1;
         b_flush = (n == 0) || ($urandom_range(7) == 0);
         b_vn = 2'($urandom);
         b_in = 16'($urandom);
         hv[n] = b_vn; hd[n] = b_in; hf[n] = b_flush;
         @(negedge clk);
         exp_v = '0;
         exp_cnt = 0;
         for (int u = n - NB; u < n; u++) begin
            if (u >= 0) begin
               alive = 1'b1;
               for (int w = u; w < n; w++) if (hf[w]) alive = 1'b0;
               if (alive) begin
                  exp_cnt += $countones(hv[u]);
                  if (u == n - NB) exp_v = hv[u];
               end
            end
         end
         if (n >= 1) begin
            tests++;
            if (b_ovn !== exp_v) begin
               fails++; $display("FAIL rand_ovn n=%0d: got %b want %b", n, b_ovn, exp_v);
            end
            tests++;
            if (b_if !== 4'(exp_cnt)) begin
               fails++; $display("FAIL rand_inflight n=%0d: got %0d want %0d", n, b_if, exp_cnt);
            end
            for (int k = 0; k < 2; k++) begin
               if (prev_exp_v[k]) begin
                  tests++;
                  if (b_out[k*8 +: 8] !== hd[n-NB][k*8 +: 8]) begin
                     fails++; $display("FAIL rand_out n=%0d lane%0d: got %h want %h", n, k,
                                       b_out[k*8 +: 8], hd[n-NB][k*8 +: 8]);
                  end
               end
            end
         end
         prev_exp_v = exp_v;
      end
   endtask

   task automatic test_full_flush();
      for (int c = -1; c < 16; c++) begin
         @(posedge clk); #1;
         b_flush = (c == -1) || (c == 10);
         b_vn = (c >= 0 && c <= 10) ? 2'b11 : 2'b00;
         b_in = (c == 10) ? 16'hEEEE : 16'(c);
         @(negedge clk);
         if (c >= 4 && c <= 10) begin
            tests++;
            if (b_if !== 4'd8 || b_ovn !== 2'b11) begin
               fails++; $display("FAIL full c=%0d: if=%0d ovn=%b want 8/11", c, b_if, b_ovn);
            end
         end
         if (c >= 11) begin
            tests++;
            if (b_if !== 4'd0 || b_ovn !== 2'b00) begin
               fails++; $display("FAIL flush c=%0d: if=%0d ovn=%b want 0/00", c, b_if, b_ovn);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      for (int c = -1; c < 4; c++) begin
         @(posedge clk); #1;
         b_flush = (c == -1);
         b_vn = (c == 0 || c == 1) ? 2'b11 : ((c == 2) ? 2'b01 : 2'b00);
         b_in = 16'h1234;
         @(negedge clk);
      end
      tests++;
      if (b_if !== 4'd5) begin
         fails++; $display("FAIL prereset_inflight: got %0d want 5", b_if);
      end
      b_vn = 2'b11;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (b_if !== 4'd0 || b_ovn !== 2'b00) begin
         fails++; $display("FAIL async_reset: if=%0d ovn=%b want 0/00", b_if, b_ovn);
      end
`ifdef BR_DELAY_VALID_NEXT_DATA_RESET_EN
      tests++;
      if (b_out !== 16'h0000) begin
         fails++; $display("FAIL async_reset_data: got %h want 0000", b_out);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      b_vn = '0;
      @(negedge clk);
      tests++;
      if (b_if !== 4'd0 || b_ovn !== 2'b00) begin
         fails++; $display("FAIL post_reset: if=%0d ovn=%b want 0/00", b_if, b_ovn);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_idle_lanes();
      test_passthrough();
      test_back_to_back();
      test_random();
      test_full_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/br_delay_valid_next_lanes.md
# br_delay_valid_next_lanes

Multi-lane, flushable successor to the single-lane valid-next delay line. NumLanes independent lanes share NumStages pipeline stages. Each lane carries its own valid_next, and its data runs one cycle behind it, so the wide datapath fanout sits on a different cycle from the long wire. The block adds a synchronous flush that kills in-flight items and a registered in-flight occupancy count, for long-haul buses that must drain or abort cleanly.

## Interface
Parameters:
- BitWidth, 1, data bits per lane; must be >= 1.
- NumLanes, 1, independent lanes; must be >= 1.
- NumStages, 0, pipeline registers per lane; must be >= 0.
- CountWidth, $clog2(NumStages*NumLanes+1), derived local width of the occupancy count (minimum 1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- flush  input  1  synchronous kill of all in-flight items, including this cycle's input.
- in_valid_next  input  NumLanes  per-lane valid, one cycle ahead of in.
- in  input  NumLanes*BitWidth  per-lane data; lane k occupies bits [k*BitWidth +: BitWidth].
- out_valid_next  output  NumLanes  per-lane valid, one cycle ahead of out.
- out  output  NumLanes*BitWidth  per-lane delayed data.
- in_flight  output  CountWidth  number of set stage valid_next registers across all lanes.

## Operation
- Stage 0 is the input. For each lane k and each stage i in 1..NumStages:
  - vn[i][k] <= flush ? 0 : vn[i-1][k].
  - data[i][k] loads data[i-1][k] only when vn[i][k] == 1. Current vn[i] marks data[i-1] valid, so clock gating is per lane.
- out_valid_next = vn[NumStages]; out = data[NumStages].
- flush does not clear data registers. Data loads in the flush cycle still follow the current vn[i], so items already qualified complete their final data load.
- in_flight is a register:
  - Normal cycle: next = in_flight + popcount(in_valid_next) - popcount(vn[NumStages]).
  - Flush cycle: next = 0.
  - in_flight always equals popcount of vn[1..NumStages] across lanes; it never exceeds NumStages*NumLanes and never wraps.
- NumStages == 0: pure combinational passthrough. flush is ignored, and in_flight is tied to 0.
- Lanes are fully independent; no ordering or coupling between lanes.

## Timing
- Reset (rst_n low, asynchronous): all vn registers 0, out_valid_next 0, in_flight 0.
  - out is X unless BR_DELAY_VALID_NEXT_DATA_RESET_EN is defined.
- Reset deassertion mid-stream: the pipeline restarts empty. Inputs presented before the first rising edge with rst_n high are lost.
- Latency: in_valid_next at cycle t gives out_valid_next at t+NumStages; the matching in at t+1 gives out at t+NumStages+1.
- Flush asserted at cycle t:
  - out_valid_next is 0 from t+1 through t+NumStages (input at t is dropped).
  - in_flight is 0 at t+1.
  - out_valid_next at cycle t itself is unaffected (registered).
- Flush and in_valid_next in the same cycle: the input is dropped. Flush in consecutive cycles is legal and idempotent.
- Full occupancy (all stages, all lanes valid) with continuous input: in_flight holds at NumStages*NumLanes.

## Configuration
- Macro BR_DELAY_VALID_NEXT_DATA_RESET_EN.
- Defined: every data register asynchronously resets to 0 on rst_n low, so out is 0 out of reset.
- Undefined (default): data registers have no reset, for area and timing; only the valid/count path is reset.
- Valid, flush and count behaviour are identical in both builds.

## Structure
- Shared package br_delay_pkg holds:
  - a function computing popcount over a NumLanes vector;
  - the CountWidth derivation helper.
- Natural sub-module br_delay_valid_next_lane: one lane's vn/data chain with flush and clock gating, instantiated NumLanes times.
- The top level adds the occupancy counter, integration checks (static parameter asserts, cover of flush while in_flight > 0) and implementation asserts:
  - valid delay;
  - data delay;
  - in_flight == popcount(vn[1..NumStages]);
  - out_valid_next == 0 in the NumStages cycles after flush.

## Test plan
- NumStages=3, NumLanes=1, BitWidth=8: in_valid_next=1 at t0, in=0xA5 at t1 -> out_valid_next=1 at t3, out=0xA5 at t4, in_flight=1 during t1..t3.
- NumStages=2, NumLanes=4: lanes 0 and 2 valid every cycle, lanes 1 and 3 idle -> in_flight settles at 4; idle lanes' out_valid_next stay 0 and their data registers never toggle.
- NumStages=4, NumLanes=2: fill to in_flight=8, then flush with in_valid_next=2'b11 -> in_flight=0 next cycle; out_valid_next=0 for 4 cycles; the flush-cycle input never appears at the output.
- NumStages=0: random in_valid_next/in/flush -> outputs equal inputs combinationally; in_flight=0.
- Assert rst_n low asynchronously mid-clock with in_flight=5 -> out_valid_next and in_flight are 0 immediately. With DATA_RESET_EN defined, out=0 as well.
- NumStages=1, NumLanes=3: back-to-back full input for 20 cycles -> in_flight=3 every cycle; each out equals the in from one cycle earlier, per lane.
